// File: rtl/gray_seq_ctrl.sv
// Programmable Gray-code sequencer: loads a binary start value, steps N codes up/down, pulses done.
// Latency: start sampled at edge k, start code at k+1, last code at k+1+N, done high after edge k+2+N.
// Backpressure: none; start is ignored while busy, step_mode gates advances on the step strobe.
// Optional: define GRAY_STEP_CHECK_EN to add the sticky single-bit-change checker output err.
module gray_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             dir,
  input  logic             step_mode,
  input  logic             step,
  input  logic [WIDTH-1:0] load_val,
  input  logic [CNT_W-1:0] num_steps,
  output logic [WIDTH-1:0] gray_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
`ifdef GRAY_STEP_CHECK_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] BIN_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [WIDTH-1:0]   gray_q, gray_d;
  logic [CNT_W-1:0]   steps_q, steps_d;
  logic [WIDTH-1:0]   load_q, load_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic               dir_q, dir_d;
  logic               mode_q, mode_d;
  logic               adv;
  logic [WIDTH-1:0]   bin_step;

  // Next-state, command capture and datapath update; every output is taken from registers.
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    gray_d   = gray_q;
    steps_d  = steps_q;
    load_d   = load_q;
    num_d    = num_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    adv      = 1'b0;
    bin_step = dir_q ? (bin_q - BIN_ONE) : (bin_q + BIN_ONE);

    case (state_q)
      S_IDLE: begin
        // start beats a concurrent abort; abort alone has nothing to cancel here
        if (start) begin
          load_d  = load_val;
          num_d   = num_steps;
          dir_d   = dir;
          mode_d  = step_mode;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          bin_d   = load_q;
          gray_d  = bin2gray(load_q);
          steps_d = num_q;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (steps_q == '0) begin
          state_d = S_DONE;
        end else if (!mode_q || step) begin
          adv = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (adv) begin
      bin_d   = bin_step;
      gray_d  = bin2gray(bin_step);
      steps_d = steps_q - CNT_ONE;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      gray_q  <= '0;
      steps_q <= '0;
      load_q  <= '0;
      num_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      steps_q <= steps_d;
      load_q  <= load_d;
      num_q   <= num_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  assign gray_out   = gray_q;
  assign steps_left = steps_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

`ifdef GRAY_STEP_CHECK_EN
  logic             err_q;
  logic [WIDTH-1:0] gray_diff;
  logic             one_bit;

  // A legal step flips exactly one bit: diff is non-zero and a power of two.
  always_comb begin
    gray_diff = gray_d ^ gray_q;
    one_bit   = (gray_diff != '0) && ((gray_diff & (gray_diff - BIN_ONE)) == '0);
  end

  // Sticky error flag, cleared on the transition into LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == S_IDLE && state_d == S_LOAD) begin
      err_q <= 1'b0;
    end else if (adv && !one_bit) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_gray_seq_ctrl.sv
module tb_gray_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       dir;
  logic       step_mode;
  logic       step;
  logic [7:0] load_val;
  logic [7:0] num_steps;
  logic [7:0] gray_out;
  logic       busy;
  logic       done;
  logic [7:0] steps_left;
`ifdef GRAY_STEP_CHECK_EN
  logic       err;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0] gray;
    logic [7:0] steps;
    logic       busy;
    logic       done;
    logic       chk_data;
  } exp_t;

  exp_t exp_q[$];

  gray_seq_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .dir        (dir),
    .step_mode  (step_mode),
    .step       (step),
    .load_val   (load_val),
    .num_steps  (num_steps),
    .gray_out   (gray_out),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
`ifdef GRAY_STEP_CHECK_EN
    ,
    .err        (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bitwise reference encoder: g[i] = b[i] ^ b[i+1], MSB passes through.
  function automatic logic [7:0] ref_gray(input logic [7:0] b);
    logic [7:0] g;
    for (int i = 0; i < 7; i++) g[i] = b[i] ^ b[i+1];
    g[7] = b[7];
    return g;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [7:0] lv, input logic [7:0] n,
                           input logic d, input logic m);
    load_val  = lv;
    num_steps = n;
    dir       = d;
    step_mode = m;
    start     = 1'b1;
  endtask

  // Expected per-cycle outputs for a free-run sequence, starting with the LOAD cycle.
  task automatic push_run(input logic [7:0] lv, input int n, input logic d);
    exp_t e;
    logic [7:0] b;
    e = '{gray: 8'h00, steps: 8'h00, busy: 1'b1, done: 1'b0, chk_data: 1'b0};
    exp_q.push_back(e);
    b = lv;
    e = '{gray: ref_gray(b), steps: 8'(n), busy: 1'b1, done: 1'b0, chk_data: 1'b1};
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      b = d ? b - 8'd1 : b + 8'd1;
      e = '{gray: ref_gray(b), steps: 8'(n - 1 - i), busy: 1'b1, done: 1'b0, chk_data: 1'b1};
      exp_q.push_back(e);
    end
    e = '{gray: ref_gray(b), steps: 8'h00, busy: 1'b1, done: 1'b1, chk_data: 1'b1};
    exp_q.push_back(e);
    e = '{gray: ref_gray(b), steps: 8'h00, busy: 1'b0, done: 1'b0, chk_data: 1'b1};
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    exp_t e;
    int idx;
    idx = 0;
    while (exp_q.size() > 0) begin
      tick();
      start = 1'b0;
      abort = 1'b0;
      step  = 1'b0;
      e = exp_q.pop_front();
      tests_run++;
      if (busy !== e.busy || done !== e.done ||
          (e.chk_data && (gray_out !== e.gray || steps_left !== e.steps))) begin
        tests_failed++;
        $display("FAIL %s[%0d]: got gray=%h steps=%0d busy=%b done=%b, want gray=%h steps=%0d busy=%b done=%b",
                 name, idx, gray_out, steps_left, busy, done, e.gray, e.steps, e.busy, e.done);
      end
      idx++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0; dir = 0; step_mode = 0; step = 0;
    load_val = 8'h00; num_steps = 8'h00;
    #3;
    tests_run++;
    if (gray_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || steps_left !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset: gray=%h busy=%b done=%b steps=%0d, want 00/0/0/0",
               gray_out, busy, done, steps_left);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if (busy !== 1'b0 || gray_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_idle: busy=%b gray=%h, want 0/00", busy, gray_out);
    end
  endtask

  task automatic test_up_count();
    start_cmd(8'h00, 8'd4, 1'b0, 1'b0);
    push_run(8'h00, 4, 1'b0);
    drain("up_count");
    tests_run++;
    if (gray_out !== 8'h06) begin
      tests_failed++;
      $display("FAIL up_final: gray=%h, want 06", gray_out);
    end
  endtask

  task automatic test_down_wrap();
    start_cmd(8'h00, 8'd2, 1'b1, 1'b0);
    push_run(8'h00, 2, 1'b1);
    drain("down_wrap");
    tests_run++;
    if (gray_out !== 8'h81) begin
      tests_failed++;
      $display("FAIL down_final: gray=%h, want 81", gray_out);
    end
  endtask

  task automatic test_step_mode();
    logic [7:0] want_g [3];
    logic [7:0] want_s [3];
    want_g[0] = 8'h07; want_g[1] = 8'h05; want_g[2] = 8'h04;
    want_s[0] = 8'd2;  want_s[1] = 8'd1;  want_s[2] = 8'd0;
    start_cmd(8'h05, 8'd2, 1'b0, 1'b1);
    tick();
    start = 1'b0;
    tick();
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 9; c++) begin
        if (p == 2) break;
        tests_run++;
        if (gray_out !== want_g[p] || steps_left !== want_s[p] || done !== 1'b0) begin
          tests_failed++;
          $display("FAIL step_hold[%0d.%0d]: gray=%h steps=%0d done=%b, want %h/%0d/0",
                   p, c, gray_out, steps_left, done, want_g[p], want_s[p]);
        end
        tick();
      end
      if (p < 2) begin
        step = 1'b1;
        tick();
        step = 1'b0;
        tests_run++;
        if (gray_out !== want_g[p+1] || steps_left !== want_s[p+1]) begin
          tests_failed++;
          $display("FAIL step_adv[%0d]: gray=%h steps=%0d, want %h/%0d",
                   p, gray_out, steps_left, want_g[p+1], want_s[p+1]);
        end
      end
    end
    tick();
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b1 || gray_out !== 8'h04) begin
      tests_failed++;
      $display("FAIL step_done: done=%b busy=%b gray=%h, want 1/1/04", done, busy, gray_out);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL step_idle: done=%b busy=%b, want 0/0", done, busy);
    end
    // step and abort together: abort wins and no step is taken
    start_cmd(8'h40, 8'd3, 1'b0, 1'b1);
    tick();
    start = 1'b0;
    tick();
    step = 1'b1;
    abort = 1'b1;
    tick();
    step = 1'b0;
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || gray_out !== 8'h60 || steps_left !== 8'd3) begin
      tests_failed++;
      $display("FAIL step_abort: busy=%b done=%b gray=%h steps=%0d, want 0/0/60/3",
               busy, done, gray_out, steps_left);
    end
  endtask

  task automatic test_abort();
    int seen_done;
    start_cmd(8'h30, 8'd10, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    tick();
    // start while busy with a different value must not disturb the run
    load_val = 8'hAA;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || gray_out !== 8'h2B || steps_left !== 8'd8) begin
      tests_failed++;
      $display("FAIL abort: busy=%b done=%b gray=%h steps=%0d, want 0/0/2b/8",
               busy, done, gray_out, steps_left);
    end
    seen_done = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || gray_out !== 8'h2B) seen_done++;
    end
    tests_run++;
    if (seen_done != 0) begin
      tests_failed++;
      $display("FAIL abort_hold: %0d bad idle cycles, want 0", seen_done);
    end
    // abort together with start in IDLE: start wins
    start_cmd(8'h21, 8'd1, 1'b0, 1'b0);
    abort = 1'b1;
    push_run(8'h21, 1, 1'b0);
    drain("start_beats_abort");
  endtask

  task automatic test_zero_steps();
    start_cmd(8'h10, 8'd0, 1'b0, 1'b0);
    push_run(8'h10, 0, 1'b0);
    drain("zero_steps");
    tests_run++;
    if (gray_out !== 8'h18) begin
      tests_failed++;
      $display("FAIL zero_final: gray=%h, want 18", gray_out);
    end
  endtask

  task automatic test_reset_mid_run();
    start_cmd(8'h55, 8'd20, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (gray_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || steps_left !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid: gray=%h busy=%b done=%b steps=%0d, want 00/0/0/0",
               gray_out, busy, done, steps_left);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_run();
    start_cmd(8'h00, 8'd255, 1'b0, 1'b0);
    push_run(8'h00, 255, 1'b0);
    drain("full_up");
`ifdef GRAY_STEP_CHECK_EN
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_full: err=%b, want 0", err);
    end
`endif
    start_cmd(8'hFF, 8'd1, 1'b0, 1'b0);
    push_run(8'hFF, 1, 1'b0);
    drain("wrap_up");
    tests_run++;
    if (gray_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL wrap_final: gray=%h, want 00", gray_out);
    end
`ifdef GRAY_STEP_CHECK_EN
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_wrap: err=%b, want 0", err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_wrap();
    test_step_mode();
    test_abort();
    test_zero_steps();
    test_reset_mid_run();
    test_full_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
